// File: rtl/layer2_controller.sv
// layer2_controller
//   Output layer of the classifier. It latches one packed activation vector from
//   Layer1_Controller and forms OUT_NODES signed dot products, one input column per
//   cycle. It then adds the per-node biases and runs a sequential argmax. Scores and
//   the winning class are held until downstream acknowledges them.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   inputsReady         : upstream vector valid (sampled only in IDLE)
//   layer1Output        : IN_NODES x IN_WIDTH unsigned activations, node 0 in MSBs
//   outputsRecieved     : downstream acknowledge (sampled only in DONE)
//   weightWriteEnable   : write one weight column selected by WriteAddressSelect
//   biasWriteEnable     : write the bias vector
//   WriteAddressSelect  : input index (column) for weight writes
//   writeIn             : OUT_NODES x W_WIDTH signed weights/biases, node 0 in MSBs
//   inputsRecieved      : one-cycle acknowledge to upstream after accept
//   outputsReady        : result valid
//   layer2Output        : OUT_NODES x ACC_WIDTH signed scores, node 0 in MSBs
//   classification      : index of the highest score (ties go to the lowest index)
module layer2_controller #(
  parameter int IN_NODES    = 2,
  parameter int IN_WIDTH    = 4,
  parameter int OUT_NODES   = 10,
  parameter int W_WIDTH     = 4,
  parameter int ACC_WIDTH   = 12,
  parameter int CLASS_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inputsReady,
  input  logic [IN_NODES*IN_WIDTH-1:0]   layer1Output,
  input  logic                           outputsRecieved,
  input  logic                           weightWriteEnable,
  input  logic                           biasWriteEnable,
  input  logic [9:0]                     WriteAddressSelect,
  input  logic [OUT_NODES*W_WIDTH-1:0]   writeIn,
  output logic                           inputsRecieved,
  output logic                           outputsReady,
  output logic [OUT_NODES*ACC_WIDTH-1:0] layer2Output,
  output logic [CLASS_WIDTH-1:0]         classification
);

  localparam int PW    = IN_WIDTH + W_WIDTH + 1;
  localparam int COL_W = (IN_NODES > 1) ? $clog2(IN_NODES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [IN_WIDTH-1:0]           in_q   [IN_NODES];
  logic [IN_WIDTH-1:0]           in_d   [IN_NODES];
  logic signed [W_WIDTH-1:0]     w_q    [OUT_NODES][IN_NODES];
  logic signed [W_WIDTH-1:0]     w_d    [OUT_NODES][IN_NODES];
  logic signed [W_WIDTH-1:0]     bias_q [OUT_NODES];
  logic signed [W_WIDTH-1:0]     bias_d [OUT_NODES];
  logic signed [ACC_WIDTH-1:0]   acc_q  [OUT_NODES];
  logic signed [ACC_WIDTH-1:0]   acc_d  [OUT_NODES];
  logic signed [ACC_WIDTH-1:0]   score_q[OUT_NODES];
  logic signed [ACC_WIDTH-1:0]   score_d[OUT_NODES];
  logic [COL_W-1:0]              col_q, col_d;
  logic [CLASS_WIDTH-1:0]        best_q, best_d;
  logic [CLASS_WIDTH-1:0]        idx_q, idx_d;
  logic [CLASS_WIDTH-1:0]        class_q, class_d;
  logic                          in_rcv_q, in_rcv_d;
  logic                          out_rdy_q, out_rdy_d;

  // Unpacked views of the packed buses (node 0 sits in the most-significant field)
  logic [IN_WIDTH-1:0]           act_in  [IN_NODES];
  logic signed [W_WIDTH-1:0]     wr_field[OUT_NODES];

  for (genvar g = 0; g < IN_NODES; g++) begin : g_act
    assign act_in[g] = layer1Output[(IN_NODES-1-g)*IN_WIDTH +: IN_WIDTH];
  end

  for (genvar g = 0; g < OUT_NODES; g++) begin : g_wr
    assign wr_field[g] = writeIn[(OUT_NODES-1-g)*W_WIDTH +: W_WIDTH];
  end

  // Current-column operands and the per-node products
  logic [IN_WIDTH-1:0]           act_cur;
  logic signed [PW-1:0]          act_ext;
  logic signed [PW-1:0]          w_ext   [OUT_NODES];
  logic signed [PW-1:0]          prod    [OUT_NODES];
  logic signed [ACC_WIDTH-1:0]   prod_ext[OUT_NODES];
  logic signed [ACC_WIDTH-1:0]   bias_ext[OUT_NODES];
  logic signed [ACC_WIDTH-1:0]   acc_idx, acc_best;

  always_comb begin
    act_cur = '0;
    for (int unsigned k = 0; k < IN_NODES; k++) begin
      if (col_q == COL_W'(k)) act_cur = in_q[k];
    end
    // Activation is unsigned: zero-extend so it stays non-negative in the signed product
    act_ext = {{(PW-IN_WIDTH){1'b0}}, act_cur};
    for (int unsigned j = 0; j < OUT_NODES; j++) begin
      w_ext[j] = '0;
      for (int unsigned k = 0; k < IN_NODES; k++) begin
        if (col_q == COL_W'(k)) w_ext[j] = {{(PW-W_WIDTH){w_q[j][k][W_WIDTH-1]}}, w_q[j][k]};
      end
      prod[j]     = act_ext * w_ext[j];
      prod_ext[j] = {{(ACC_WIDTH-PW){prod[j][PW-1]}}, prod[j]};
      bias_ext[j] = {{(ACC_WIDTH-W_WIDTH){bias_q[j][W_WIDTH-1]}}, bias_q[j]};
    end
  end

  // Operands of the argmax comparison
  always_comb begin
    acc_idx  = '0;
    acc_best = '0;
    for (int unsigned j = 0; j < OUT_NODES; j++) begin
      if (idx_q == CLASS_WIDTH'(j))  acc_idx  = acc_q[j];
      if (best_q == CLASS_WIDTH'(j)) acc_best = acc_q[j];
    end
  end

  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    w_d       = w_q;
    bias_d    = bias_q;
    acc_d     = acc_q;
    score_d   = score_q;
    col_d     = col_q;
    best_d    = best_q;
    idx_d     = idx_q;
    class_d   = class_q;
    in_rcv_d  = 1'b0;
    out_rdy_d = out_rdy_q;

    // Coefficient updates are only safe while no computation is using them
    if (state_q == S_IDLE || state_q == S_DONE) begin
      if (weightWriteEnable) begin
        for (int unsigned k = 0; k < IN_NODES; k++) begin
          if (WriteAddressSelect == 10'(k)) begin
            for (int unsigned j = 0; j < OUT_NODES; j++) w_d[j][k] = wr_field[j];
          end
        end
      end
      if (biasWriteEnable) begin
        for (int unsigned j = 0; j < OUT_NODES; j++) bias_d[j] = wr_field[j];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (inputsReady) begin
          in_d     = act_in;
          for (int unsigned j = 0; j < OUT_NODES; j++) acc_d[j] = '0;
          col_d    = '0;
          in_rcv_d = 1'b1;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        for (int unsigned j = 0; j < OUT_NODES; j++) acc_d[j] = acc_q[j] + prod_ext[j];
        col_d = col_q + COL_W'(1);
        if (col_q == COL_W'(IN_NODES-1)) state_d = S_BIAS;
      end
      S_BIAS: begin
        for (int unsigned j = 0; j < OUT_NODES; j++) begin
          acc_d[j]   = acc_q[j] + bias_ext[j];
          score_d[j] = acc_d[j];
        end
        best_d  = '0;
        idx_d   = CLASS_WIDTH'(1);
        class_d = '0;
        state_d = S_ARGMAX;
      end
      S_ARGMAX: begin
        // Strict compare keeps the earlier index on ties
        if (acc_idx > acc_best) best_d = idx_q;
        class_d = best_d;
        idx_d   = idx_q + CLASS_WIDTH'(1);
        if (idx_q == CLASS_WIDTH'(OUT_NODES-1)) begin
          state_d   = S_DONE;
          out_rdy_d = 1'b1;
        end
      end
      S_DONE: begin
        if (outputsRecieved) begin
          out_rdy_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      best_q    <= '0;
      idx_q     <= '0;
      class_q   <= '0;
      in_rcv_q  <= 1'b0;
      out_rdy_q <= 1'b0;
      for (int unsigned k = 0; k < IN_NODES; k++) in_q[k] <= '0;
      for (int unsigned j = 0; j < OUT_NODES; j++) begin
        acc_q[j]   <= '0;
        score_q[j] <= '0;
        bias_q[j]  <= '0;
        for (int unsigned k = 0; k < IN_NODES; k++) w_q[j][k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      best_q    <= best_d;
      idx_q     <= idx_d;
      class_q   <= class_d;
      in_rcv_q  <= in_rcv_d;
      out_rdy_q <= out_rdy_d;
      in_q      <= in_d;
      acc_q     <= acc_d;
      score_q   <= score_d;
      bias_q    <= bias_d;
      w_q       <= w_d;
    end
  end

  always_comb begin
    layer2Output = '0;
    for (int unsigned j = 0; j < OUT_NODES; j++) begin
      layer2Output[(OUT_NODES-1-j)*ACC_WIDTH +: ACC_WIDTH] = score_q[j];
    end
  end

  assign inputsRecieved = in_rcv_q;
  assign outputsReady   = out_rdy_q;
  assign classification = class_q;

endmodule

// File: tb/tb_layer2_controller.sv
// Self-checking bench for layer2_controller: directed vector table, hand-written
// handshake/reset sequences and randomized runs against a behavioural score model.
module tb_layer2_controller;

  localparam int IN_NODES    = 2;
  localparam int IN_WIDTH    = 4;
  localparam int OUT_NODES   = 10;
  localparam int W_WIDTH     = 4;
  localparam int ACC_WIDTH   = 12;
  localparam int CLASS_WIDTH = 4;

  logic                           clk = 1'b0;
  logic                           reset = 1'b1;
  logic                           inputsReady = 1'b0;
  logic [IN_NODES*IN_WIDTH-1:0]   layer1Output = '0;
  logic                           outputsRecieved = 1'b0;
  logic                           weightWriteEnable = 1'b0;
  logic                           biasWriteEnable = 1'b0;
  logic [9:0]                     WriteAddressSelect = '0;
  logic [OUT_NODES*W_WIDTH-1:0]   writeIn = '0;
  logic                           inputsRecieved;
  logic                           outputsReady;
  logic [OUT_NODES*ACC_WIDTH-1:0] layer2Output;
  logic [CLASS_WIDTH-1:0]         classification;

  layer2_controller #(
    .IN_NODES(IN_NODES), .IN_WIDTH(IN_WIDTH), .OUT_NODES(OUT_NODES),
    .W_WIDTH(W_WIDTH), .ACC_WIDTH(ACC_WIDTH), .CLASS_WIDTH(CLASS_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .inputsReady(inputsReady), .layer1Output(layer1Output),
    .outputsRecieved(outputsRecieved), .weightWriteEnable(weightWriteEnable),
    .biasWriteEnable(biasWriteEnable), .WriteAddressSelect(WriteAddressSelect),
    .writeIn(writeIn), .inputsRecieved(inputsRecieved), .outputsReady(outputsReady),
    .layer2Output(layer2Output), .classification(classification)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the coefficient memories as written by the bench
  int mw[OUT_NODES][IN_NODES];
  int mb[OUT_NODES];

  typedef struct {
    logic [39:0] col0;
    logic [39:0] col1;
    logic [39:0] bias;
    logic [7:0]  inp;
    int          exp_class;
    int          key_node;
    int          key_score;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int nib(input logic [39:0] d, input int j);
    logic [3:0] n;
    n = d[(OUT_NODES-1-j)*W_WIDTH +: W_WIDTH];
    return int'($signed(n));
  endfunction

  function automatic int dut_score(input int j);
    logic [ACC_WIDTH-1:0] f;
    f = layer2Output[(OUT_NODES-1-j)*ACC_WIDTH +: ACC_WIDTH];
    return int'($signed(f));
  endfunction

  function automatic int model_score(input int j, input logic [7:0] inp);
    int a0, a1, r;
    a0 = int'(inp[7:4]);
    a1 = int'(inp[3:0]);
    r  = a0 * mw[j][0] + a1 * mw[j][1] + mb[j];
    r  = ((r % 4096) + 4096) % 4096;
    if (r >= 2048) r -= 4096;
    return r;
  endfunction

  // Highest score, first occurrence wins
  function automatic int model_class(input logic [7:0] inp);
    int mx;
    mx = model_score(0, inp);
    for (int j = 1; j < OUT_NODES; j++) if (model_score(j, inp) > mx) mx = model_score(j, inp);
    for (int j = 0; j < OUT_NODES; j++) if (model_score(j, inp) == mx) return j;
    return 0;
  endfunction

  task automatic check_model(input string tag, input logic [7:0] inp);
    for (int j = 0; j < OUT_NODES; j++)
      check($sformatf("%s_score%0d", tag, j), dut_score(j), model_score(j, inp));
    check({tag, "_class"}, int'(classification), model_class(inp));
  endtask

  task automatic write_ctrl(input logic we, input logic be, input logic [9:0] addr,
                            input logic [39:0] data);
    @(negedge clk);
    weightWriteEnable  = we;
    biasWriteEnable    = be;
    WriteAddressSelect = addr;
    writeIn            = data;
    @(negedge clk);
    weightWriteEnable = 1'b0;
    biasWriteEnable   = 1'b0;
    for (int j = 0; j < OUT_NODES; j++) begin
      if (we && addr < 10'(IN_NODES)) mw[j][int'(addr)] = nib(data, j);
      if (be) mb[j] = nib(data, j);
    end
  endtask

  task automatic wait_ready(output int cnt, output int pulses);
    cnt = 0;
    pulses = 0;
    while (!outputsReady && cnt < 40) begin
      @(negedge clk);
      cnt++;
      weightWriteEnable = 1'b0;
      biasWriteEnable   = 1'b0;
      if (inputsRecieved) pulses++;
    end
  endtask

  // One full transaction: accept, compute, hold in DONE, acknowledge
  task automatic run(input logic [7:0] inp, input bit hold_ready, input bit mac_write);
    int cnt, pulses;
    @(negedge clk);
    inputsReady  = 1'b1;
    layer1Output = inp;
    @(negedge clk);
    check("accept_ack", int'(inputsRecieved), 1);
    if (!hold_ready) inputsReady = 1'b0;
    if (mac_write) begin
      weightWriteEnable  = 1'b1;
      biasWriteEnable    = 1'b1;
      WriteAddressSelect = '0;
      writeIn            = '1;
    end
    wait_ready(cnt, pulses);
    check("ready_latency", cnt, 12);
    check("no_reaccept", pulses, 0);
    check_model("result", inp);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("done_hold_ready", int'(outputsReady), 1);
      check("done_hold_class", int'(classification), model_class(inp));
    end
    outputsRecieved = 1'b1;
    @(negedge clk);
    outputsRecieved = 1'b0;
    check("ack_clears_ready", int'(outputsReady), 0);
    if (hold_ready) begin
      check("no_accept_on_ack_edge", int'(inputsRecieved), 0);
      @(negedge clk);
      check("accept_after_ack", int'(inputsRecieved), 1);
      inputsReady = 1'b0;
      wait_ready(cnt, pulses);
      check("ready_latency2", cnt, 12);
      check_model("rerun", inp);
      outputsRecieved = 1'b1;
      @(negedge clk);
      outputsRecieved = 1'b0;
      check("ack_clears_ready2", int'(outputsReady), 0);
    end else begin
      check("idle_no_ack", int'(inputsRecieved), 0);
    end
    check_model("idle_hold", inp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, int'(outputsReady), 0);
    check({tag, "_inrcv"}, int'(inputsRecieved), 0);
    check({tag, "_class"}, int'(classification), 0);
    check({tag, "_scores_nonzero"}, int'(|layer2Output), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [7:0]  inp;
    for (int j = 0; j < OUT_NODES; j++) begin
      mb[j] = 0;
      for (int k = 0; k < IN_NODES; k++) mw[j][k] = 0;
    end

    tbl[0] = '{40'h3E00000000, 40'h0, 40'h0, 8'h60, 0, 0, 18};
    tbl[1] = '{40'h0002000000, 40'h0003000000, 40'h0000000700, 8'h12, 3, 3, 8};
    tbl[2] = '{40'h0040040000, 40'h0, 40'h0, 8'h10, 2, 5, 4};
    tbl[3] = '{40'h0, 40'h0, 40'h0, 8'hFF, 0, 9, 0};
    tbl[4] = '{40'h8888888888, 40'h8888888888, 40'h0000000001, 8'hFF, 9, 9, -239};
    tbl[5] = '{40'h7777777777, 40'h7777777777, 40'h7777777777, 8'hFF, 0, 0, 217};

    // Reset held for two edges
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      write_ctrl(1'b1, 1'b0, 10'd0, tbl[i].col0);
      write_ctrl(1'b1, 1'b0, 10'd1, tbl[i].col1);
      write_ctrl(1'b0, 1'b1, 10'd0, tbl[i].bias);
      run(tbl[i].inp, 1'b0, 1'b0);
      check($sformatf("tbl%0d_class", i), int'(classification), tbl[i].exp_class);
      check($sformatf("tbl%0d_key", i), dut_score(tbl[i].key_node), tbl[i].key_score);
    end

    // Reset during MAC drops the vector and clears coefficients
    @(negedge clk);
    inputsReady  = 1'b1;
    layer1Output = 8'hF0;
    @(negedge clk);
    inputsReady = 1'b0;
    check("midmac_accept", int'(inputsRecieved), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midmac_reset");
    for (int j = 0; j < OUT_NODES; j++) begin
      mb[j] = 0;
      for (int k = 0; k < IN_NODES; k++) mw[j][k] = 0;
    end
    repeat (15) @(negedge clk);
    check("midmac_dropped", int'(outputsReady), 0);
    run(8'hFF, 1'b0, 1'b0);
    check("after_reset_class", int'(classification), 0);

    // Handshake corners with nonzero coefficients
    write_ctrl(1'b1, 1'b0, 10'd0, 40'h1234567F9A);
    write_ctrl(1'b1, 1'b1, 10'd1, 40'hC3D2E1F0A5);
    run(8'hA5, 1'b1, 1'b0);
    run(8'h3C, 1'b0, 1'b1);
    write_ctrl(1'b1, 1'b0, 10'd2, 40'h7777777777);
    write_ctrl(1'b1, 1'b0, 10'd512, 40'h8888888888);
    run(8'h9E, 1'b0, 1'b0);

    // Randomized coefficient writes and vectors
    repeat (25) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        r = {$urandom(), $urandom()};
        write_ctrl(1'b1, ($urandom_range(0, 3) == 0), 10'($urandom_range(0, 3)), r[39:0]);
      end
      inp = 8'($urandom());
      run(inp, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
